// File: rtl/input_spike_dispatcher_pkg.sv
// Shared widths and FSM encoding for the input spike dispatcher.
package input_spike_dispatcher_pkg;

  localparam int unsigned BT_WIDTH_DEFAULT     = 36;
  localparam int unsigned NEURON_WIDTH_DEFAULT = 11;
  localparam int unsigned COUNT_WIDTH_DEFAULT  = 16;
  localparam int unsigned BT_FRAC_BITS         = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_DEQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    StIdle  = ST_IDLE,
    StCheck = ST_CHECK,
    StDeq   = ST_DEQ,
    StWait  = ST_WAIT,
    StEmit  = ST_EMIT,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/spike_handoff_reg.sv
// Valid/ready holding register for one spike on its way to the router.
module spike_handoff_reg
  import input_spike_dispatcher_pkg::*;
#(
  parameter int unsigned BT_WIDTH     = BT_WIDTH_DEFAULT,
  parameter int unsigned NEURON_WIDTH = NEURON_WIDTH_DEFAULT
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [BT_WIDTH-1:0]     in_bt,
  input  logic [NEURON_WIDTH-1:0] in_nid,
  input  logic                    ready,
  output logic                    valid,
  output logic [BT_WIDTH-1:0]     bt,
  output logic [NEURON_WIDTH-1:0] nid
);

  logic                    valid_q;
  logic [BT_WIDTH-1:0]     bt_q;
  logic [NEURON_WIDTH-1:0] nid_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q <= 1'b0;
      bt_q    <= '0;
      nid_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      bt_q    <= in_bt;
      nid_q   <= in_nid;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign bt    = bt_q;
  assign nid   = nid_q;

endmodule

// File: rtl/input_spike_dispatcher.sv
// Drains due spikes from the input FIFO to the router once per timestep.
module input_spike_dispatcher
  import input_spike_dispatcher_pkg::*;
#(
  parameter int unsigned BT_WIDTH     = BT_WIDTH_DEFAULT,
  parameter int unsigned NEURON_WIDTH = NEURON_WIDTH_DEFAULT,
  parameter int unsigned COUNT_WIDTH  = COUNT_WIDTH_DEFAULT
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [BT_WIDTH-1:0]     CurrentBT,
  input  logic [BT_WIDTH-1:0]     BT_Head,
  input  logic                    IsQueueEmpty,
  input  logic [BT_WIDTH-1:0]     BTOut,
  input  logic [NEURON_WIDTH-1:0] NIDOut,
  output logic                    QueueEnable,
  output logic                    Dequeue,
  output logic                    SpikeValid,
  input  logic                    SpikeReady,
  output logic [NEURON_WIDTH-1:0] SpikeNID,
  output logic [BT_WIDTH-1:0]     SpikeBT,
  output logic                    RoutingComplete,
  output logic                    Busy,
  output logic [COUNT_WIDTH-1:0]  DispatchedCount
);

  state_e                 state_q;
  logic [BT_WIDTH-1:0]    cur_bt_q;
  logic                   dequeue_q;
  logic                   done_q;
  logic                   busy_q;
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      cur_bt_q  <= '0;
      dequeue_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      dequeue_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            cur_bt_q <= CurrentBT;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          // Head is re-read here every time, after the FIFO pointers have settled.
          if (IsQueueEmpty || (BT_Head > cur_bt_q)) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            dequeue_q <= 1'b1;
            state_q   <= StDeq;
          end
        end
        StDeq:  state_q <= StWait;
        StWait: state_q <= StEmit;
        StEmit: begin
          if (SpikeReady) begin
            if (count_q != '1) count_q <= count_q + 1'b1;
            state_q <= StCheck;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO data arrives during WAIT, one cycle after the Dequeue strobe.
  spike_handoff_reg #(
    .BT_WIDTH     (BT_WIDTH),
    .NEURON_WIDTH (NEURON_WIDTH)
  ) u_handoff (
    .Clock  (Clock),
    .Reset  (Reset),
    .load   (state_q == StWait),
    .in_bt  (BTOut),
    .in_nid (NIDOut),
    .ready  (SpikeReady),
    .valid  (SpikeValid),
    .bt     (SpikeBT),
    .nid    (SpikeNID)
  );

  assign QueueEnable     = ~Reset;
  assign Dequeue         = dequeue_q;
  assign RoutingComplete = done_q;
  assign Busy            = busy_q;
  assign DispatchedCount = count_q;

endmodule

// File: tb/tb_input_spike_dispatcher.sv
// Directed bench: behavioural FIFO model, pass table plus stall/reset sequences.
module tb_input_spike_dispatcher;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [35:0] CurrentBT;
  logic [35:0] BT_Head;
  logic        IsQueueEmpty;
  logic [35:0] BTOut;
  logic [10:0] NIDOut;
  logic        QueueEnable;
  logic        Dequeue;
  logic        SpikeValid;
  logic        SpikeReady;
  logic [10:0] SpikeNID;
  logic [35:0] SpikeBT;
  logic        RoutingComplete;
  logic        Busy;
  logic [15:0] DispatchedCount;

  input_spike_dispatcher dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Start           (Start),
    .CurrentBT       (CurrentBT),
    .BT_Head         (BT_Head),
    .IsQueueEmpty    (IsQueueEmpty),
    .BTOut           (BTOut),
    .NIDOut          (NIDOut),
    .QueueEnable     (QueueEnable),
    .Dequeue         (Dequeue),
    .SpikeValid      (SpikeValid),
    .SpikeReady      (SpikeReady),
    .SpikeNID        (SpikeNID),
    .SpikeBT         (SpikeBT),
    .RoutingComplete (RoutingComplete),
    .Busy            (Busy),
    .DispatchedCount (DispatchedCount)
  );

  always #5 Clock = ~Clock;

  // FIFO model with registered read data.
  logic [35:0] fifo_bt  [64];
  logic [10:0] fifo_nid [64];
  int          wr = 0;
  int          rd = 0;
  logic        fifo_flush = 1'b0;

  assign IsQueueEmpty = (rd == wr);
  assign BT_Head      = (rd == wr) ? 36'd0 : fifo_bt[rd % 64];

  // Cumulative monitor counters; the test takes snapshots around each pass.
  int          viol = 0;
  int          deq_cnt = 0;
  int          rc_cnt = 0;
  int          got_n = 0;
  logic [10:0] got_nid [64];
  logic [35:0] got_bt  [64];

  always @(posedge Clock) begin
    if (fifo_flush) begin
      rd <= wr;
    end else if (Dequeue) begin
      if (rd == wr) viol <= viol + 1;
      else begin
        BTOut  <= fifo_bt[rd % 64];
        NIDOut <= fifo_nid[rd % 64];
        rd     <= rd + 1;
      end
    end
    if (Dequeue) deq_cnt <= deq_cnt + 1;
    if (Dequeue && SpikeValid) viol <= viol + 1;
    if (SpikeValid && SpikeReady && !Reset) begin
      got_nid[got_n % 64] <= SpikeNID;
      got_bt[got_n % 64]  <= SpikeBT;
      got_n               <= got_n + 1;
    end
    if (RoutingComplete) rc_cnt <= rc_cnt + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [35:0] bt, input logic [10:0] nid);
    fifo_bt[wr % 64]  = bt;
    fifo_nid[wr % 64] = nid;
    wr++;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset      = 1'b1;
    Start      = 1'b0;
    fifo_flush = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    Reset      = 1'b0;
    fifo_flush = 1'b0;
  endtask

  // Pulses Start at a negedge, returns cycles until RoutingComplete is seen.
  task automatic run_pass(input logic [35:0] cur, output int lat);
    @(negedge Clock);
    Start     = 1'b1;
    CurrentBT = cur;
    lat       = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge Clock);
      Start = 1'b0;
      if (RoutingComplete) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        keep;
    int          n;
    logic [35:0] bt0, bt1, bt2;
    logic [10:0] nid0, nid1, nid2;
    logic [35:0] cur;
    int          exp_disp;
    logic [10:0] exp_first_nid;
    logic [35:0] exp_first_bt;
    logic [10:0] exp_last_nid;
    int          exp_left;
  } vec_t;

  vec_t vec [6];

  initial begin
    int lat, g0, r0, left;

    vec[0] = '{1'b0, 0, 36'h0, 36'h0, 36'h0, 11'd0, 11'd0, 11'd0, 36'h10, 0, 11'd0, 36'h0, 11'd0, 0};
    vec[1] = '{1'b0, 3, 36'h10, 36'h10, 36'h20, 11'd5, 11'd9, 11'd3, 36'h10, 2, 11'd5, 36'h10,
               11'd9, 1};
    vec[2] = '{1'b1, 0, 36'h0, 36'h0, 36'h0, 11'd0, 11'd0, 11'd0, 36'h30, 1, 11'd3, 36'h20, 11'd3, 0};
    vec[3] = '{1'b0, 1, 36'h08, 36'h0, 36'h0, 11'd7, 11'd0, 11'd0, 36'h40, 1, 11'd7, 36'h08, 11'd7, 0};
    vec[4] = '{1'b0, 1, 36'h11, 36'h0, 36'h0, 11'd1, 11'd0, 11'd0, 36'h10, 0, 11'd0, 36'h0, 11'd0, 1};
    vec[5] = '{1'b0, 3, 36'h05, 36'h06, 36'h07, 11'd1, 11'd2, 11'd4, 36'hF_FFFF_FFFF, 3, 11'd1,
               36'h05, 11'd4, 0};

    Reset = 1'b1; Start = 1'b0; CurrentBT = '0; SpikeReady = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("reset_queue_enable", QueueEnable, 0);
    check("reset_outputs", {Dequeue, SpikeValid, RoutingComplete, Busy}, 0);
    check("reset_count", DispatchedCount, 0);
    check("reset_spike_data", {SpikeNID, SpikeBT}, 0);
    Reset = 1'b0;
    @(negedge Clock);
    check("queue_enable_after_reset", QueueEnable, 1);

    // Table of complete passes with the router always ready.
    SpikeReady = 1'b1;
    foreach (vec[i]) begin
      if (!vec[i].keep) do_reset();
      if (vec[i].n > 0) push(vec[i].bt0, vec[i].nid0);
      if (vec[i].n > 1) push(vec[i].bt1, vec[i].nid1);
      if (vec[i].n > 2) push(vec[i].bt2, vec[i].nid2);
      g0 = got_n;
      r0 = rc_cnt;
      run_pass(vec[i].cur, lat);
      @(negedge Clock);
      check($sformatf("v%0d_latency", i), lat, 2 + 4 * vec[i].exp_disp);
      check($sformatf("v%0d_count", i), DispatchedCount, vec[i].exp_disp);
      check($sformatf("v%0d_accepted", i), got_n - g0, vec[i].exp_disp);
      check($sformatf("v%0d_rc_pulses", i), rc_cnt - r0, 1);
      check($sformatf("v%0d_busy_after", i), Busy, 0);
      left = wr - rd;
      check($sformatf("v%0d_fifo_left", i), left, vec[i].exp_left);
      if (vec[i].exp_disp > 0) begin
        check($sformatf("v%0d_first_nid", i), got_nid[g0 % 64], vec[i].exp_first_nid);
        check($sformatf("v%0d_first_bt", i), got_bt[g0 % 64], vec[i].exp_first_bt);
        check($sformatf("v%0d_last_nid", i), got_nid[(got_n - 1) % 64], vec[i].exp_last_nid);
      end
    end

    // Router stalls the first spike; a mid-pass Start with CurrentBT=0 must not relatch.
    do_reset();
    push(36'h10, 11'd5); push(36'h10, 11'd9); push(36'h20, 11'd3);
    SpikeReady = 1'b0;
    g0 = got_n;
    @(negedge Clock);
    Start = 1'b1; CurrentBT = 36'h10;
    @(negedge Clock);
    Start = 1'b0;
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      if (SpikeValid) begin lat = k; break; end
      @(negedge Clock);
    end
    check("stall_valid_seen", lat >= 0, 1);
    r0 = deq_cnt;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_hold_%0d", k), {SpikeValid, SpikeNID, SpikeBT}, {1'b1, 11'd5, 36'h10});
      if (k == 1) begin Start = 1'b1; CurrentBT = 36'h0; end
      else Start = 1'b0;
      @(negedge Clock);
    end
    check("stall_no_extra_deq", deq_cnt - r0, 0);
    check("stall_busy", Busy, 1);
    SpikeReady = 1'b1;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (RoutingComplete) begin lat = k; break; end
      @(negedge Clock);
    end
    check("stall_done_seen", lat >= 0, 1);
    check("stall_count", DispatchedCount, 2);
    check("stall_order", {got_nid[g0 % 64], got_nid[(g0 + 1) % 64]}, {11'd5, 11'd9});
    check("stall_head_left", BT_Head, 36'h20);

    // Reset while a spike is held in EMIT: no RoutingComplete, everything cleared.
    do_reset();
    push(36'h10, 11'd5);
    SpikeReady = 1'b0;
    @(negedge Clock);
    Start = 1'b1; CurrentBT = 36'h10;
    @(negedge Clock);
    Start = 1'b0;
    for (int k = 0; k < 50 && !SpikeValid; k++) @(negedge Clock);
    check("emit_reached", SpikeValid, 1);
    r0 = rc_cnt;
    Reset = 1'b1;
    @(negedge Clock);
    check("midreset_qe", QueueEnable, 0);
    check("midreset_outputs", {Dequeue, SpikeValid, RoutingComplete, Busy}, 0);
    Reset = 1'b0;
    @(negedge Clock);
    check("postreset_outputs", {QueueEnable, Dequeue, SpikeValid, RoutingComplete, Busy}, 5'b10000);
    check("postreset_data", {DispatchedCount, SpikeNID, SpikeBT}, 0);
    SpikeReady = 1'b1;
    repeat (10) @(negedge Clock);
    check("postreset_idle", {Busy, Dequeue}, 0);
    check("postreset_no_rc", rc_cnt - r0, 0);

    check("dequeue_protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
